// File: rtl/edge_gen_pkg.sv
// rtl/edge_gen_pkg.sv - shared FSM state type and helpers for pulse_to_edge_gen
package edge_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// rtl/sat_updown_cnt.sv - saturating up/down counter for pending requests
module sat_updown_cnt #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q;

  // Simultaneous inc and dec cancel; each direction clamps at its bound.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc && !dec && (cnt_q != MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign full = (cnt_q == MAX);

endmodule

// File: rtl/pulse_to_edge_gen.sv
// rtl/pulse_to_edge_gen.sv - turns request strobes into spaced high windows on edge_o
module pulse_to_edge_gen
  import edge_gen_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_W      = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic              edge_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              overflow_o
);

  generate
    if (HIGH_CYCLES < 1 || LOW_CYCLES < 1 || PEND_W < 1) begin : g_param_check
      $error("pulse_to_edge_gen: HIGH_CYCLES, LOW_CYCLES and PEND_W must all be >= 1");
    end
  endgenerate

  localparam int CNT_W = $clog2(max_int(HIGH_CYCLES, LOW_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0]  pend_cnt;
  logic               pend_full;
  logic               pend_nz;
  logic               active;
  logic               last_low;
  logic               pend_inc;
  logic               pend_dec;
  logic               overflow_d;
  logic               edge_q, busy_q, overflow_q;

  assign active   = (state_q != ST_IDLE);
  assign last_low = (state_q == ST_LOW) && (cnt_q == '0);
  assign pend_nz  = (pend_cnt != '0);

  // The last LOW cycle is the consumption point: a stored request is taken
  // from the counter, while a fresh strobe with nothing stored bypasses it.
  assign pend_dec   = last_low && pend_nz;
  assign pend_inc   = en_i && active && !(last_low && !pend_nz);
  assign overflow_d = en_i && active && !last_low && pend_full;

  sat_updown_cnt #(
    .W (PEND_W)
  ) u_pend_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (pend_inc),
    .dec    (pend_dec),
    .cnt    (pend_cnt),
    .full   (pend_full)
  );

  // Next-state and window counter: counter holds cycles remaining in the
  // current phase, so zero marks the final cycle of HIGH or LOW.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          if (pend_nz || en_i) begin
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      edge_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= (state_d == ST_HIGH);
      busy_q     <= (state_d != ST_IDLE);
      overflow_q <= overflow_d;
    end
  end

  assign edge_o     = edge_q;
  assign busy_o     = busy_q;
  assign pend_o     = pend_cnt;
  assign overflow_o = overflow_q;

  a_no_idle_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ST_IDLE) |-> (pend_cnt == '0));

endmodule

// File: doc/pulse_to_edge_gen.md
PULSE_TO_EDGE_GEN -- requirements
Module: pulse_to_edge_gen

Interface
REQ-001 SHALL have parameter HIGH_CYCLES, default 4: number of cycles edge_o is held high per request, legal range 1 or more.
REQ-002 SHALL have parameter LOW_CYCLES, default 4: number of cycles of minimum low gap after each high window, legal range 1 or more.
REQ-003 SHALL have parameter PEND_W, default 2: width of the pending-request counter, which saturates at 2^PEND_W-1.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en_i, input, 1 bit: one-cycle request strobe; each high cycle counts as one request.
REQ-007 SHALL have port edge_o, output, 1 bit: registered level output carrying exactly one rising edge per accepted request.
REQ-008 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not IDLE.
REQ-009 SHALL have port pend_o, output, PEND_W bits: current pending-request count.
REQ-010 SHALL have port overflow_o, output, 1 bit: one-cycle pulse when a request is dropped.

Function
REQ-011 SHALL implement the FSM states IDLE, HIGH and LOW; edge_o is 1 only in HIGH.
REQ-012 SHALL, in IDLE, sample en_i=1 at clock edge n, enter HIGH so that edge_o=1 from cycle n+1 (latency 1), and load the cycle counter.
REQ-013 SHALL hold HIGH for exactly HIGH_CYCLES cycles, then hold LOW for exactly LOW_CYCLES cycles.
REQ-014 SHALL, at the last LOW cycle, go to HIGH if pend_o>0 (decrementing pend_o) or if en_i=1; otherwise it SHALL go to IDLE.
REQ-015 SHALL increment pend_o when en_i=1 in HIGH or LOW, except at a consumption point.
REQ-016 SHALL resolve simultaneous events at the last LOW cycle as follows: with en_i=1 and pend_o=0, the request is consumed directly and pend_o stays 0; with en_i=1 and pend_o>0, pend_o is unchanged (net increment plus decrement).
REQ-017 SHALL, on en_i=1 with pend_o at maximum and no consumption in that cycle, drop the request, hold pend_o, and pulse overflow_o=1 in the next cycle only.
REQ-018 SHALL never be in IDLE with pend_o>0 (assertion).
REQ-019 SHALL make the period between consecutive rising edges at least HIGH_CYCLES+LOW_CYCLES.
REQ-020 SHALL size the cycle counter to clog2(max(HIGH_CYCLES,LOW_CYCLES)+1) bits and never let it wrap below 0.
REQ-021 SHALL register all outputs (no combinational path from en_i).

Reset
REQ-022 SHALL, while rst_ni=0, immediately force state=IDLE, edge_o=0, busy_o=0, pend_o=0, overflow_o=0 and counter=0, independent of clk_i.
REQ-023 SHALL abandon any in-flight high window and discard pending requests on a reset asserted mid-operation.
REQ-024 SHALL honour the first en_i sampled after rst_ni deasserts per REQ-012.

Structure
REQ-025 SHALL place the FSM state enum (IDLE/HIGH/LOW) in shared package edge_gen_pkg.
REQ-026 SHALL include a parameter-legality check (HIGH_CYCLES>=1, LOW_CYCLES>=1, PEND_W>=1) in the module.
REQ-027 SHALL implement the saturating up/down counter for pending requests as sub-module sat_updown_cnt (parameter W; inputs inc, dec; outputs cnt, full).

Verification (HIGH_CYCLES=3, LOW_CYCLES=2, PEND_W=2)
REQ-028 SHALL cover a single en_i at cycle 10: edge_o=1 during cycles 11-13 and 0 during 14-15, with busy_o=0 from cycle 16.
REQ-029 SHALL cover en_i at cycles 10, 11 and 12: pend_o reaches 2, and edge_o rises at cycles 11, 16 and 21 with no IDLE in between.
REQ-030 SHALL cover en_i at cycles 10-14: pend_o saturates at 3, overflow_o=1 only in cycle 15, and exactly 4 rising edges occur.
REQ-031 SHALL cover en_i at cycle 15 (the last LOW cycle of a cycle-10 request) with pend_o=0: edge_o rises at cycle 16 and pend_o stays 0.
REQ-032 SHALL cover rst_ni=0 at cycle 12 mid-HIGH: edge_o, busy_o and pend_o go to 0 at once; after release, en_i at cycle 20 gives edge_o=1 at cycle 21.
REQ-033 SHALL cover 2000 random en_i cycles with a rising-edge counter model: the number of rises equals the number of strobes minus overflow pulses after drain.
